// File: rtl/video_pkg.sv
// Shared video stream types: frame geometry defaults, pixel beat layout and the
// Wishbone response / responder FSM encodings.
package video_pkg;

    localparam int HDISP_DEF = 800;
    localparam int VDISP_DEF = 480;

    typedef struct packed {
        logic [31:0] data;
        logic        sof;
        logic        eol;
    } px_beat_t;

    typedef enum logic [1:0] {
        ACK = 2'd0,
        ERR = 2'd1,
        RTY = 2'd2
    } wshb_resp_e;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } wshb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output; DEPTH must be a power of 2.
// A pop on a full FIFO frees a slot in the same cycle, so a simultaneous push is accepted.
module sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_level;
    logic             w_doPop;
    logic             w_doPush;

    assign w_doPop  = i_pop && (r_level != '0);
    assign w_doPush = i_push && ((r_level != FULL_LEVEL) || w_doPop);

    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_level <= r_level + {AW'(0), w_doPush} - {AW'(0), w_doPop};
        end
    end

    assign o_data  = r_mem[r_rdPtr];
    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == FULL_LEVEL);
    assign o_level = r_level;

endmodule

// File: rtl/wshb_stream_slave.sv
// Wishbone classic responder that buffers pixel writes and re-emits them as a sof/eol tagged stream.
// Build option WSHB_STREAM_RTY_EN: a write on a full FIFO is answered with rty instead of wait states.
module wshb_stream_slave
    import video_pkg::*;
#(
    parameter int HDISP      = HDISP_DEF,
    parameter int VDISP      = VDISP_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [31:0] wb_adr,
    input  logic [3:0]  wb_sel,
    input  logic [31:0] wb_dat_ms,
    output logic [31:0] wb_dat_sm,
    output logic        wb_ack,
    output logic        wb_err,
    output logic        wb_rty,
    output logic [31:0] px_data,
    output logic        px_sof,
    output logic        px_eol,
    output logic        px_valid,
    input  logic        px_ready
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int RW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(HDISP - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(VDISP - 1);

    wshb_state_e r_state, w_stateNext;
    wshb_resp_e  r_resp, w_respNext;
    logic [31:0] r_datSm, w_datNext;
    logic [15:0] r_ovfCnt;
    logic        r_stallSeen, w_stallNext;
    logic        w_ovfInc;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic [LW-1:0] w_level;
    logic [CW-1:0] r_col, w_colCur;
    logic [RW-1:0] r_row, w_rowCur;
    px_beat_t    w_pushBeat;
    px_beat_t    w_headBeat;

    assign px_valid = !w_empty;
    assign w_pop    = px_valid && px_ready;

    // A write to address 0 restarts the frame before this word is tagged.
    assign w_colCur = (wb_adr == 32'd0) ? '0 : r_col;
    assign w_rowCur = (wb_adr == 32'd0) ? '0 : r_row;

    assign w_pushBeat.data = wb_dat_ms;
    assign w_pushBeat.sof  = (w_colCur == '0) && (w_rowCur == '0);
    assign w_pushBeat.eol  = (w_colCur == COL_LAST);

    always_comb begin
        w_stateNext = r_state;
        w_respNext  = r_resp;
        w_datNext   = '0;
        w_push      = 1'b0;
        w_ovfInc    = 1'b0;
        w_stallNext = 1'b0;
        case (r_state)
            IDLE: begin
                if (wb_cyc && wb_stb) begin
                    if (!wb_we) begin
                        w_stateNext = RESP;
                        w_respNext  = ACK;
                        w_datNext   = {r_ovfCnt, 8'(w_level), 8'(FIFO_DEPTH)};
                    end else if (wb_sel != 4'hF) begin
                        w_stateNext = RESP;
                        w_respNext  = ERR;
                    end else if (!w_full || w_pop) begin
                        w_push      = 1'b1;
                        w_stateNext = RESP;
                        w_respNext  = ACK;
                    end else begin
                        // The stall flag makes a waiting request count as one overflow.
                        w_ovfInc = !r_stallSeen;
`ifdef WSHB_STREAM_RTY_EN
                        w_stateNext = RESP;
                        w_respNext  = RTY;
`else
                        w_stallNext = 1'b1;
`endif
                    end
                end
            end
            RESP: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= IDLE;
            r_resp      <= ACK;
            r_datSm     <= '0;
            r_stallSeen <= 1'b0;
            r_ovfCnt    <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_resp      <= w_respNext;
            r_datSm     <= w_datNext;
            r_stallSeen <= w_stallNext;
            if (w_ovfInc && (r_ovfCnt != 16'hFFFF)) begin
                r_ovfCnt <= r_ovfCnt + 16'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_push) begin
            if (w_colCur == COL_LAST) begin
                r_col <= '0;
                r_row <= (w_rowCur == ROW_LAST) ? '0 : w_rowCur + 1'b1;
            end else begin
                r_col <= w_colCur + 1'b1;
                r_row <= w_rowCur;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(px_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_push  (w_push),
        .i_data  (w_pushBeat),
        .i_pop   (w_pop),
        .o_data  (w_headBeat),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_level (w_level)
    );

    assign wb_ack    = (r_state == RESP) && (r_resp == ACK);
    assign wb_err    = (r_state == RESP) && (r_resp == ERR);
`ifdef WSHB_STREAM_RTY_EN
    assign wb_rty    = (r_state == RESP) && (r_resp == RTY);
`else
    assign wb_rty    = 1'b0;
`endif
    assign wb_dat_sm = r_datSm;

    assign px_data = px_valid ? w_headBeat.data : '0;
    assign px_sof  = px_valid && w_headBeat.sof;
    assign px_eol  = px_valid && w_headBeat.eol;

endmodule

// File: tb/tb_wshb_stream_slave.sv
// Self-checking bench for wshb_stream_slave: directed scenarios plus randomized traffic
// scored against a queue-based pixel model; follows WSHB_STREAM_RTY_EN like the design.
module tb_wshb_stream_slave;
    localparam int HDISP = 800;
    localparam int VDISP = 4;
    localparam int DEPTH = 16;
    localparam int RSP_ACK  = 0;
    localparam int RSP_ERR  = 1;
    localparam int RSP_RTY  = 2;
    localparam int RSP_NONE = 3;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [31:0] wb_adr = '0, wb_dat_ms = '0;
    logic [3:0]  wb_sel = '0;
    logic [31:0] wb_dat_sm;
    logic        wb_ack, wb_err, wb_rty;
    logic [31:0] px_data;
    logic        px_sof, px_eol, px_valid;
    logic        px_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [33:0] expQ[$];
    logic [33:0] monExp;
    int modelPix = 0;
    int modelOvf = 0;
    int beatCount = 0, eolCount = 0, eolBeat = 0;

    int          lastResp;
    logic [31:0] lastRdata;
    logic [31:0] ackPxData;
    logic        ackPxSof, ackPxEol;

    always #5 sys_clk = ~sys_clk;

    wshb_stream_slave #(
        .HDISP      (HDISP),
        .VDISP      (VDISP),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_adr    (wb_adr),
        .wb_sel    (wb_sel),
        .wb_dat_ms (wb_dat_ms),
        .wb_dat_sm (wb_dat_sm),
        .wb_ack    (wb_ack),
        .wb_err    (wb_err),
        .wb_rty    (wb_rty),
        .px_data   (px_data),
        .px_sof    (px_sof),
        .px_eol    (px_eol),
        .px_valid  (px_valid),
        .px_ready  (px_ready)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Pixel position is a linear index into the frame; adr 0 restarts it.
    function automatic void modelPush(input logic [31:0] adr, input logic [31:0] data);
        if (adr == 32'd0) modelPix = 0;
        expQ.push_back({data, modelPix == 0, (modelPix % HDISP) == HDISP - 1});
        modelPix = (modelPix + 1) % (HDISP * VDISP);
    endfunction

    // Stream side: every beat taken must be the model's next beat.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            checkOutput("px_valid", px_valid, expQ.size() != 0);
            if (px_valid && px_ready) begin
                beatCount++;
                if (px_eol) begin
                    eolCount++;
                    eolBeat = beatCount;
                end
                if (expQ.size() == 0) begin
                    checkOutput("unexpected beat", 1, 0);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("beat", {px_data, px_sof, px_eol}, monExp);
                end
            end
        end
    end

    task automatic resetDut();
        sys_rst_n = 1'b0;
        wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_sel = '0; wb_dat_ms = '0;
        px_ready = 0;
        expQ.delete();
        modelPix = 0; modelOvf = 0; beatCount = 0; eolCount = 0; eolBeat = 0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
    endtask

    // One Wishbone request. readyMode: 0 hold px_ready, 1 randomize each cycle,
    // 2 hold until the response then drop px_ready.
    task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                                 input logic [31:0] data, input int readyMode, input int maxWait);
        int sz, expResp, lat, hot;
        bit stall;
        logic [31:0] expStat;
        if (readyMode == 1) px_ready = 1'($urandom_range(0, 1));
        sz = expQ.size();
        stall = we && (sel == 4'hF) && (sz == DEPTH) && !(px_ready && sz > 0);
        expStat = {16'(modelOvf), 8'(sz), 8'(DEPTH)};
        if (stall && modelOvf < 65535) modelOvf++;
        if (!we)                expResp = RSP_ACK;
        else if (sel != 4'hF)   expResp = RSP_ERR;
        else if (!stall)        expResp = RSP_ACK;
`ifdef WSHB_STREAM_RTY_EN
        else                    expResp = RSP_RTY;
`else
        else                    expResp = (readyMode == 1) ? RSP_ACK : RSP_NONE;
`endif
        wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat_ms = data;
        lastResp = RSP_NONE; lastRdata = '0; lat = 0;
        for (int i = 0; i < maxWait; i++) begin
            @(posedge sys_clk);
            #1;
            lat = i + 1;
            if (wb_ack || wb_err || wb_rty) begin
                hot = int'(wb_ack) + int'(wb_err) + int'(wb_rty);
                checkOutput("resp onehot", hot, 1);
                lastResp  = wb_ack ? RSP_ACK : (wb_err ? RSP_ERR : RSP_RTY);
                lastRdata = wb_dat_sm;
                ackPxData = px_data; ackPxSof = px_sof; ackPxEol = px_eol;
                if (wb_ack && we && sel == 4'hF) modelPush(adr, data);
                break;
            end
            if (readyMode == 1) px_ready = 1'($urandom_range(0, 1));
        end
        if (readyMode == 2) px_ready = 0;
        checkOutput("resp", lastResp, expResp);
        if (stall && expResp == RSP_ACK) checkOutput("stall latency", lat > 1, 1);
        else if (expResp != RSP_NONE)    checkOutput("latency", lat, 1);
        if (!we && lastResp == RSP_ACK)  checkOutput("status", lastRdata, expStat);
        else if (lastResp != RSP_NONE)   checkOutput("dat_sm zero", lastRdata, 0);
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
        @(posedge sys_clk);
        #1;
        checkOutput("idle quiet", {wb_ack, wb_err, wb_rty, wb_dat_sm}, 0);
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rnd;
        logic        rdWe;
        logic [3:0]  rdSel;
        logic [31:0] rdAdr;

        sys_rst_n = 1'b0;
        #1;
        checkOutput("reset outputs", {wb_ack, wb_err, wb_rty, px_valid, px_sof, px_eol, px_data, wb_dat_sm}, 0);
        resetDut();
        checkOutput("post-reset valid", px_valid, 0);

        $display("[TB] single write and line/frame tagging");
        px_ready = 1;
        applyStimulus(1, 32'h0, 4'hF, 32'hA5A5_0001, 0, 16);
        checkOutput("first ack", lastResp, RSP_ACK);
        checkOutput("first px_data", ackPxData, 32'hA5A5_0001);
        checkOutput("first sof", ackPxSof, 1);
        checkOutput("first eol", ackPxEol, 0);
        for (int i = 0; i < 799; i++) applyStimulus(1, 32'h4, 4'hF, $urandom, 0, 16);
        checkOutput("eol count after 800", eolCount, 1);
        checkOutput("eol beat index", eolBeat, 800);
        applyStimulus(1, 32'h4, 4'hF, $urandom, 0, 16);
        checkOutput("beat 801 sof", ackPxSof, 0);
        checkOutput("beat 801 eol", ackPxEol, 0);
        for (int i = 0; i < HDISP * VDISP - 801; i++) applyStimulus(1, 32'h4, 4'hF, $urandom, 0, 16);
        checkOutput("eol count per frame", eolCount, VDISP);
        applyStimulus(1, 32'h4, 4'hF, 32'h1234_5678, 0, 16);
        checkOutput("new frame sof", ackPxSof, 1);
        checkOutput("new frame data", ackPxData, 32'h1234_5678);

        $display("[TB] overflow with blocked stream");
        resetDut();
        px_ready = 0;
        for (int i = 0; i < 17; i++) applyStimulus(1, 32'h4, 4'hF, 32'hC0DE_0000 + i, 0, 8);
        applyStimulus(0, 32'h8, 4'hF, 0, 0, 16);
        checkOutput("full status", lastRdata, 32'h0001_1010);

        $display("[TB] bad byte select");
        applyStimulus(1, 32'h4, 4'h3, 32'hDEAD_BEEF, 0, 16);
        checkOutput("err resp", lastResp, RSP_ERR);
        applyStimulus(0, 32'h8, 4'hF, 0, 0, 16);
        checkOutput("level after err", lastRdata, 32'h0001_1010);

        $display("[TB] push and pop on full");
        px_ready = 1;
        applyStimulus(1, 32'h4, 4'hF, 32'hF00D_0001, 2, 16);
        checkOutput("full push ack", lastResp, RSP_ACK);
        applyStimulus(0, 32'h8, 4'hF, 0, 0, 16);
        checkOutput("level stays full", lastRdata, 32'h0001_1010);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            rnd   = $urandom;
            rdWe  = (rnd[2:0] != 3'd0);
            rdSel = (rnd[7:3] == 5'd0) ? 4'(rnd[11:8]) : 4'hF;
            rdAdr = (rnd[16:12] == 5'd0) ? 32'h0 : {rnd[31:20], 2'b00} | 32'h4;
            applyStimulus(rdWe, rdAdr, rdSel, $urandom, 1, 64);
        end
        px_ready = 1;
        repeat (DEPTH + 2) @(posedge sys_clk);
        #1;
        checkOutput("drained", expQ.size(), 0);

        $display("[TB] reset during response");
        resetDut();
        px_ready = 0;
        for (int i = 0; i < 5; i++) applyStimulus(1, 32'h4, 4'hF, 32'hBEEF_0000 + i, 0, 16);
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'h4; wb_sel = 4'hF; wb_dat_ms = 32'h5555_AAAA;
        @(posedge sys_clk);
        #1;
        checkOutput("ack before reset", wb_ack, 1);
        sys_rst_n = 1'b0;
        expQ.delete(); modelPix = 0; modelOvf = 0;
        #1;
        checkOutput("ack drops in reset", wb_ack, 0);
        checkOutput("valid drops in reset", px_valid, 0);
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        applyStimulus(0, 32'h8, 4'hF, 0, 0, 16);
        checkOutput("empty after reset", lastRdata, 32'h0000_0010);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
